// File: rtl/div_iter.sv
// Iterative restoring divider. It retires BITS_PER_CYCLE quotient bits per cycle and
// applies signed fix-up and divide-by-zero results in a single final cycle.
module div_iter #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic            kill,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_divzero,
    output logic            busy
);
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_divzero;
    logic [XLEN-1:0] r_num;
    logic [XLEN-1:0] r_div;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_result;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_signed;
    logic            w_zero_div;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_num_nxt;
    logic [XLEN-1:0] w_fix_result;

    assign req_ready   = (r_state == IDLE) && !kill;
    assign rsp_valid   = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign rsp_result  = r_result;
    assign rsp_divzero = r_divzero;

    assign w_accept   = req_valid && req_ready;
    assign w_signed   = ~req_op[0];
    assign w_zero_div = (req_src2 == '0);
    // Negating the most negative value wraps to itself, which is exactly 2^(XLEN-1) unsigned.
    assign w_abs1 = (w_signed && req_src1[XLEN-1]) ? -req_src1 : req_src1;
    assign w_abs2 = (w_signed && req_src2[XLEN-1]) ? -req_src2 : req_src2;

    // Unrolled restoring steps; the quotient shifts into r_num as the dividend shifts out.
    always_comb begin
        logic [XLEN:0] w_shift;
        logic [XLEN:0] w_diff;
        w_rem_nxt = r_rem;
        w_num_nxt = r_num;
        w_shift   = '0;
        w_diff    = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_shift   = {w_rem_nxt, w_num_nxt[XLEN-1]};
            w_diff    = w_shift - {1'b0, r_div};
            w_rem_nxt = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
            w_num_nxt = {w_num_nxt[XLEN-2:0], ~w_diff[XLEN]};
        end
    end

    // On divide-by-zero r_num holds the raw dividend, since no CALC cycles run.
    always_comb begin
        w_fix_result = '0;
        if (r_divzero) begin
            w_fix_result = r_is_rem ? r_num : '1;
        end else if (r_is_rem) begin
            w_fix_result = r_neg_r ? -r_rem : r_rem;
        end else begin
            w_fix_result = r_neg_q ? -r_num : r_num;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = w_zero_div ? FIX : CALC;
            CALC: if (r_cnt == CW'(N - 1)) w_state_next = FIX;
            FIX:  w_state_next = DONE;
            DONE: if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (kill) w_state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_divzero <= 1'b0;
            r_num     <= '0;
            r_div     <= '0;
            r_rem     <= '0;
            r_result  <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_rem  <= req_op[1];
                        r_neg_q   <= w_signed && (req_src1[XLEN-1] ^ req_src2[XLEN-1]);
                        r_neg_r   <= w_signed && req_src1[XLEN-1];
                        r_divzero <= w_zero_div;
                        r_num     <= w_zero_div ? req_src1 : w_abs1;
                        r_div     <= w_abs2;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_num <= w_num_nxt;
                    r_cnt <= r_cnt + CW'(1);
                end
                FIX: begin
                    r_result <= w_fix_result;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: two instances (32-bit radix-2 and 64-bit radix-16) checked against
// directed corner cases and a randomized sweep scored by an arithmetic reference model.
module tb_div_iter;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        kill;
    logic        rsp_ready;
    logic [1:0]  req_op;
    logic [63:0] src1;
    logic [63:0] src2;

    logic        vld_a, rdy_a, rv_a, dz_a, busy_a;
    logic [31:0] res_a;
    logic        vld_b, rdy_b, rv_b, dz_b, busy_b;
    logic [63:0] res_b;

    int          inst_sel = 0;
    logic        cur_ready, cur_valid, cur_dz, cur_busy;
    logic [63:0] cur_result;

    int n_checks = 0;
    int n_errors = 0;

    div_iter #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut32 (
        .clk(clk), .reset(reset), .req_valid(vld_a), .req_ready(rdy_a),
        .req_op(req_op), .req_src1(src1[31:0]), .req_src2(src2[31:0]), .kill(kill),
        .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_result(res_a),
        .rsp_divzero(dz_a), .busy(busy_a)
    );

    div_iter #(.XLEN(64), .BITS_PER_CYCLE(4)) u_dut64 (
        .clk(clk), .reset(reset), .req_valid(vld_b), .req_ready(rdy_b),
        .req_op(req_op), .req_src1(src1), .req_src2(src2), .kill(kill),
        .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_result(res_b),
        .rsp_divzero(dz_b), .busy(busy_b)
    );

    assign cur_ready  = (inst_sel == 1) ? rdy_b  : rdy_a;
    assign cur_valid  = (inst_sel == 1) ? rv_b   : rv_a;
    assign cur_dz     = (inst_sel == 1) ? dz_b   : dz_a;
    assign cur_busy   = (inst_sel == 1) ? busy_b : busy_a;
    assign cur_result = (inst_sel == 1) ? res_b  : {32'd0, res_a};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division with the RISC-V corner-case conventions; returns {divzero, result}.
    function automatic logic [64:0] ref_div(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input int w);
        logic [63:0] mask, ua, ub, q, r;
        longint sa, sb;
        logic dz;
        mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        ua = a & mask;
        ub = b & mask;
        sa = (w == 32) ? longint'(signed'(ua[31:0])) : longint'(ua);
        sb = (w == 32) ? longint'(signed'(ub[31:0])) : longint'(ub);
        dz = 1'b0;
        if (ub == 64'd0) begin
            dz = 1'b1;
            q  = mask;
            r  = ua;
        end else if (op[0]) begin
            q = ua / ub;
            r = ua % ub;
        end else if (w == 64 && ua == 64'h8000_0000_0000_0000 && sb == -1) begin
            q = ua;
            r = 64'd0;
        end else begin
            q = 64'(sa / sb);
            r = 64'(sa % sb);
        end
        return {dz, (op[1] ? r : q) & mask};
    endfunction

    // Issues one request to the chosen instance and waits for its response;
    // when rsp_ready is high it also lets the handshake edge pass.
    task automatic run_op(input int inst, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] res, output logic dz,
                          output int lat);
        int guard;
        inst_sel = inst;
        @(negedge clk);
        req_op = op;
        src1   = a;
        src2   = b;
        if (inst == 1) vld_b = 1'b1; else vld_a = 1'b1;
        guard = 0;
        while (!cur_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("accept_in_time", 64'(guard < 100), 64'd1);
        @(posedge clk);
        @(negedge clk);
        vld_a  = 1'b0;
        vld_b  = 1'b0;
        src1   = {$urandom, $urandom};
        src2   = {$urandom, $urandom};
        req_op = 2'($urandom);
        lat = 0;
        while (!cur_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        res = cur_result;
        dz  = cur_dz;
        $display("inst=%0d op=%0d a=0x%0h b=0x%0h res=0x%0h dz=%0b lat=%0d",
                 inst, op, a, b, res, dz, lat);
        if (rsp_ready) @(negedge clk);
    endtask

    function automatic logic [63:0] pick(input int w);
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = '1;
            2:       v = (w == 32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
            3:       v = 64'($urandom_range(0, 20));
            4:       v = '1 - 64'($urandom_range(0, 20));
            default: v = {$urandom, $urandom};
        endcase
        return (w == 32) ? (v & 64'hFFFF_FFFF) : v;
    endfunction

    typedef struct {
        int          inst;
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic        exp_dz;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [63:0] res, held;
        logic        dz;
        int          lat, seen, w, nlat;
        logic [64:0] r;

        reset = 1'b1; kill = 1'b0; rsp_ready = 1'b1; req_op = 2'd0;
        src1 = '0; src2 = '0; vld_a = 1'b0; vld_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("reset_rsp_valid", {63'd0, rv_a}, 64'd0);
        check_eq("reset_result", {32'd0, res_a}, 64'd0);
        check_eq("reset_divzero", {63'd0, dz_a}, 64'd0);
        check_eq("reset_busy", {63'd0, busy_a}, 64'd0);
        check_eq("reset_req_ready", {63'd0, rdy_a}, 64'd1);

        vecs[0] = '{0, 2'b01, 64'd100,        64'd7,        64'd14,                   1'b0};
        vecs[1] = '{0, 2'b00, 64'hFFFFFF9C,   64'd7,        64'hFFFFFFF2,             1'b0};
        vecs[2] = '{0, 2'b10, 64'hFFFFFF9C,   64'd7,        64'hFFFFFFFE,             1'b0};
        vecs[3] = '{0, 2'b11, 64'hFFFFFF9C,   64'd7,        64'd2,                    1'b0};
        vecs[4] = '{0, 2'b01, 64'd5,          64'd0,        64'hFFFFFFFF,             1'b1};
        vecs[5] = '{0, 2'b10, 64'h80000000,   64'd0,        64'h80000000,             1'b1};
        vecs[6] = '{0, 2'b00, 64'h80000000,   64'hFFFFFFFF, 64'h80000000,             1'b0};
        vecs[7] = '{0, 2'b10, 64'h80000000,   64'hFFFFFFFF, 64'd0,                    1'b0};
        vecs[8] = '{1, 2'b01, 64'h0123456789ABCDEF, 64'h10, 64'h00123456789ABCDE,     1'b0};

        foreach (vecs[k]) begin
            run_op(vecs[k].inst, vecs[k].op, vecs[k].a, vecs[k].b, res, dz, lat);
            nlat = vecs[k].exp_dz ? 1 : ((vecs[k].inst == 1) ? 17 : 33);
            check_eq($sformatf("dir%0d_result", k), res, vecs[k].exp);
            check_eq($sformatf("dir%0d_divzero", k), {63'd0, dz}, {63'd0, vecs[k].exp_dz});
            check_eq($sformatf("dir%0d_latency", k), 64'(lat), 64'(nlat));
            check_eq($sformatf("dir%0d_busy_after", k), {63'd0, cur_busy}, 64'd0);
        end

        // Backpressure: response must hold while the consumer stalls.
        rsp_ready = 1'b0;
        run_op(0, 2'b01, 64'd1000, 64'd3, held, dz, lat);
        check_eq("bp_result", held, 64'd333);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq($sformatf("bp_hold%0d", c), {32'd0, res_a}, held);
            check_eq($sformatf("bp_valid%0d", c), {63'd0, rv_a}, 64'd1);
            check_eq($sformatf("bp_req_ready%0d", c), {63'd0, rdy_a}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_released_busy", {63'd0, busy_a}, 64'd0);

        // Kill during CALC.
        inst_sel = 0;
        @(negedge clk);
        req_op = 2'b01; src1 = 64'd12345; src2 = 64'd11; vld_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld_a = 1'b0;
        repeat (4) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        check_eq("kill_busy", {63'd0, busy_a}, 64'd0);
        check_eq("kill_valid", {63'd0, rv_a}, 64'd0);
        check_eq("kill_blocks_ready", {63'd0, rdy_a}, 64'd0);
        kill = 1'b0;
        #1;
        check_eq("kill_ready_back", {63'd0, rdy_a}, 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rv_a) seen++;
        end
        check_eq("kill_no_response", 64'(seen), 64'd0);

        // Reset in the middle of CALC.
        @(negedge clk);
        req_op = 2'b01; src1 = 64'hFFFFFFFF; src2 = 64'd3; vld_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld_a = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_valid", {63'd0, rv_a}, 64'd0);
        check_eq("rst_mid_result", {32'd0, res_a}, 64'd0);
        check_eq("rst_mid_divzero", {63'd0, dz_a}, 64'd0);
        check_eq("rst_mid_busy", {63'd0, busy_a}, 64'd0);
        check_eq("rst_mid_result64", res_b, 64'd0);
        reset = 1'b0;

        // Randomized sweep on both instances.
        for (int inst = 0; inst < 2; inst++) begin
            w = (inst == 1) ? 64 : 32;
            for (int t = 0; t < 30; t++) begin
                logic [1:0]  op;
                logic [63:0] a, b;
                op = 2'($urandom);
                a  = pick(w);
                b  = pick(w);
                r  = ref_div(op, a, b, w);
                run_op(inst, op, a, b, res, dz, lat);
                nlat = r[64] ? 1 : ((inst == 1) ? 17 : 33);
                check_eq($sformatf("rnd%0d_%0d_result", inst, t), res, r[63:0]);
                check_eq($sformatf("rnd%0d_%0d_divzero", inst, t), {63'd0, dz}, {63'd0, r[64]});
                check_eq($sformatf("rnd%0d_%0d_latency", inst, t), 64'(lat), 64'(nlat));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
